// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction-fetch reads and data reads/writes
// from the pipeline onto one single-ported memory. Each transaction is
// latched at grant, held on pmem_* until the memory responds, and completed
// with a one-cycle response pulse to the port that was granted.
module mem_port_arbiter #(
  parameter int D_PRIORITY   = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_wmask,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;

  // Saturating increment of the consecutive-D-grant counter.
  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    if (s >= STREAK_MAX) return STREAK_MAX;
    return s + 4'd1;
  endfunction

  assign d_req = d_read | d_write;

  // Arbitration: only meaningful in IDLE; the streak limit forces an I grant
  // so a busy data port cannot starve instruction fetch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_read && d_req) begin
        if ((D_PRIORITY != 0) && (streak != STREAK_MAX)) grant_d = 1'b1;
        else                                               grant_i = 1'b1;
      end else if (i_read) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Transaction FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      streak       <= 4'd0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wmask   <= 2'b00;
      pmem_address <= 16'h0000;
      pmem_wdata   <= 16'h0000;
      i_rdata      <= 16'h0000;
      d_rdata      <= 16'h0000;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_wmask   <= 2'b00;
            pmem_address <= i_address;
            pmem_wdata   <= 16'h0000;
            streak       <= 4'd0;
            state        <= I_BUSY;
          end else if (grant_d) begin
            pmem_address <= d_address;
            // A simultaneous read+write request is issued as a write.
            if (d_write) begin
              pmem_read  <= 1'b0;
              pmem_write <= 1'b1;
              pmem_wmask <= d_wmask;
              pmem_wdata <= d_wdata;
            end else begin
              pmem_read  <= 1'b1;
              pmem_write <= 1'b0;
              pmem_wmask <= 2'b00;
              pmem_wdata <= 16'h0000;
            end
            streak <= i_read ? streak_inc(streak) : 4'd0;
            state  <= D_BUSY;
          end
        end
        I_BUSY: begin
          if (pmem_resp) begin
            i_rdata      <= pmem_rdata;
            i_resp       <= 1'b1;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wmask   <= 2'b00;
            pmem_address <= 16'h0000;
            pmem_wdata   <= 16'h0000;
            state        <= RESP;
          end
        end
        D_BUSY: begin
          if (pmem_resp) begin
            // Writes leave the last read data untouched.
            if (!pmem_write) d_rdata <= pmem_rdata;
            d_resp       <= 1'b1;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wmask   <= 2'b00;
            pmem_address <= 16'h0000;
            pmem_wdata   <= 16'h0000;
            state        <= RESP;
          end
        end
        RESP: begin
          // One response cycle, then one forced idle cycle before re-arbitrating.
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a hand-driven memory responder.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [1:0]  d_wmask;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.D_PRIORITY(1), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until a memory strobe appears; a missing issue counts as a failure.
  task automatic wait_issue(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pmem_read || pmem_write) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_issue"}, {31'd0, seen}, 32'd1);
  endtask

  // Called in the first busy cycle; keeps the strobe for lat cycles, answering
  // in the last one. Returns in the response cycle.
  task automatic respond(input string tag, input int lat, input logic [15:0] rd);
    logic [15:0] addr0;
    addr0 = pmem_address;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_busy_strobe"}, {31'd0, pmem_read | pmem_write}, 32'd1);
      chk({tag, "_busy_addr"}, {16'd0, pmem_address}, {16'd0, addr0});
      if (k == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
      end
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0000;
  endtask

  logic [15:0] exp_addr;

  initial begin
    rst = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_wmask = 0; d_address = 0; d_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    tick(); tick();
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    chk("rst_pmem_addr", {16'd0, pmem_address}, 32'd0);
    chk("rst_resps", {30'd0, i_resp, d_resp}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single fetch, three-cycle memory latency
    i_read = 1; i_address = 16'h0040;
    tick();
    chk("t1_pmem_read", {31'd0, pmem_read}, 32'd1);
    chk("t1_pmem_addr", {16'd0, pmem_address}, 32'h0040);
    chk("t1_pmem_wmask", {30'd0, pmem_wmask}, 32'd0);
    respond("t1", 3, 16'h1234);
    chk("t1_i_resp", {31'd0, i_resp}, 32'd1);
    chk("t1_i_rdata", {16'd0, i_rdata}, 32'h1234);
    chk("t1_d_resp", {31'd0, d_resp}, 32'd0);
    chk("t1_pmem_drop", {31'd0, pmem_read}, 32'd0);
    i_read = 0;
    tick();
    chk("t1_i_resp_fall", {31'd0, i_resp}, 32'd0);
    chk("t1_i_rdata_hold", {16'd0, i_rdata}, 32'h1234);
    tick();

    // 2: simultaneous requests, D has priority
    i_read = 1; i_address = 16'h0010; d_read = 1; d_address = 16'h2000;
    tick();
    chk("t2_d_first_addr", {16'd0, pmem_address}, 32'h2000);
    chk("t2_d_first_read", {31'd0, pmem_read}, 32'd1);
    respond("t2d", 2, 16'h5555);
    chk("t2_d_resp", {31'd0, d_resp}, 32'd1);
    chk("t2_i_resp_quiet", {31'd0, i_resp}, 32'd0);
    chk("t2_d_rdata", {16'd0, d_rdata}, 32'h5555);
    d_read = 0;
    tick();
    chk("t2_idle_gap", {31'd0, pmem_read | pmem_write}, 32'd0);
    chk("t2_d_resp_fall", {31'd0, d_resp}, 32'd0);
    tick();
    chk("t2_i_second_addr", {16'd0, pmem_address}, 32'h0010);
    chk("t2_i_second_read", {31'd0, pmem_read}, 32'd1);
    respond("t2i", 1, 16'h7777);
    chk("t2_i_resp", {31'd0, i_resp}, 32'd1);
    chk("t2_d_resp_quiet", {31'd0, d_resp}, 32'd0);
    chk("t2_i_rdata", {16'd0, i_rdata}, 32'h7777);
    i_read = 0;
    tick();

    // 3: both held; four D grants, then I forced, then D again
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h2200;
    for (int g = 0; g < 6; g++) begin
      exp_addr = (g == 4) ? 16'h0100 : 16'h2200;
      wait_issue("t3");
      chk($sformatf("t3_grant%0d_addr", g), {16'd0, pmem_address}, {16'd0, exp_addr});
      respond("t3", 1, 16'h3000 + 16'(g));
      chk($sformatf("t3_grant%0d_resp", g), {30'd0, i_resp, d_resp},
          (g == 4) ? 32'd2 : 32'd1);
    end
    i_read = 0; d_read = 0;
    tick();
    chk("t3_d_rdata_last", {16'd0, d_rdata}, 32'h3005);
    chk("t3_i_rdata_last", {16'd0, i_rdata}, 32'h3004);

    // 4: masked write; d_rdata must not change
    d_write = 1; d_address = 16'h3002; d_wdata = 16'hAB00; d_wmask = 2'b10;
    wait_issue("t4");
    chk("t4_pmem_write", {31'd0, pmem_write}, 32'd1);
    chk("t4_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("t4_pmem_wmask", {30'd0, pmem_wmask}, 32'd2);
    chk("t4_pmem_wdata", {16'd0, pmem_wdata}, 32'hAB00);
    chk("t4_pmem_addr", {16'd0, pmem_address}, 32'h3002);
    respond("t4", 2, 16'hFFFF);
    chk("t4_d_resp", {31'd0, d_resp}, 32'd1);
    chk("t4_d_rdata_kept", {16'd0, d_rdata}, 32'h3005);
    d_write = 0;
    tick();

    // 4b: read+write together acts as a write, empty mask still issued
    d_read = 1; d_write = 1; d_wmask = 2'b00; d_address = 16'h3100; d_wdata = 16'h00CD;
    wait_issue("t4b");
    chk("t4b_is_write", {30'd0, pmem_write, pmem_read}, 32'd2);
    chk("t4b_wmask", {30'd0, pmem_wmask}, 32'd0);
    respond("t4b", 1, 16'hEEEE);
    chk("t4b_d_resp", {31'd0, d_resp}, 32'd1);
    chk("t4b_d_rdata_kept", {16'd0, d_rdata}, 32'h3005);
    d_read = 0; d_write = 0;
    tick();

    // 5: reset while D transaction is outstanding
    d_read = 1; d_address = 16'h4444;
    wait_issue("t5");
    tick();
    chk("t5_busy", {31'd0, pmem_read}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_read", {31'd0, pmem_read}, 32'd0);
    chk("t5_rst_addr", {16'd0, pmem_address}, 32'd0);
    d_read = 0; pmem_resp = 1; pmem_rdata = 16'h9999;
    tick();
    pmem_resp = 0; pmem_rdata = 0;
    chk("t5_no_resp0", {31'd0, d_resp}, 32'd0);
    tick();
    chk("t5_no_resp1", {31'd0, d_resp}, 32'd0);
    chk("t5_idle", {31'd0, pmem_read | pmem_write}, 32'd0);
    chk("t5_d_rdata_clr", {16'd0, d_rdata}, 32'd0);

    // 6: requester drops d_read after issue; latched address is used
    d_read = 1; d_address = 16'h5006;
    wait_issue("t6");
    d_read = 0; d_address = 16'h9999;
    tick();
    chk("t6_addr_latched", {16'd0, pmem_address}, 32'h5006);
    chk("t6_still_read", {31'd0, pmem_read}, 32'd1);
    respond("t6", 2, 16'h0BCD);
    chk("t6_d_resp", {31'd0, d_resp}, 32'd1);
    chk("t6_d_rdata", {16'd0, d_rdata}, 32'h0BCD);
    tick();
    chk("t6_d_resp_fall", {31'd0, d_resp}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_reissue", {30'd0, pmem_read, pmem_write}, 32'd0);
    end
    chk("t6_no_extra_resp", {30'd0, i_resp, d_resp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Responder end of the pipeline's memory interface. It accepts instruction-fetch reads from the fetch stage and data reads/writes from the MEM stage (mem_read_d / mem_write with a byte write mask), and serialises them onto one single-ported physical memory. It sits between the pipeline datapath and physical memory, and returns data with a one-cycle response pulse to whichever port was granted.

Parameters:
D_PRIORITY, 1, 1 = D-port wins simultaneous requests; 0 = I-port wins.
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced; range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
i_read  in  1  fetch read request; held until i_resp
i_address  in  16  fetch word address
i_rdata  out  16  fetch read data; valid while i_resp=1
i_resp  out  1  one-cycle fetch completion pulse
d_read  in  1  data read request; held until d_resp
d_write  in  1  data write request; held until d_resp
d_wmask  in  2  byte enables for writes, [1]=high byte, [0]=low byte
d_address  in  16  data address
d_wdata  in  16  write data
d_rdata  out  16  data read data; valid while d_resp=1
d_resp  out  1  one-cycle data completion pulse
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_wmask  out  2  memory byte enables
pmem_address  out  16  memory address
pmem_wdata  out  16  memory write data
pmem_rdata  in  16  memory read data; valid with pmem_resp
pmem_resp  in  1  memory completion, one cycle

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: all pmem_* = 0, i_resp = d_resp = 0, i_rdata = d_rdata = 0x0000, streak counter = 0, state = IDLE.
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE, arbitration:
  - D request = d_read | d_write.
  - Both ports requesting: the port selected by D_PRIORITY wins, unless D_PRIORITY=1 and streak = MAX_D_STREAK; then I wins.
  - Winner's address, data and mask are latched. Next state is I_BUSY or D_BUSY.
  - No request: stay in IDLE.
- Issue timing: a request seen in IDLE at edge N drives pmem_* from cycle N+1. pmem_* stay constant until pmem_resp is sampled.
- Strobe rules:
  - I transaction: pmem_read=1, pmem_wmask=00.
  - D read: pmem_read=1, pmem_wmask=00.
  - D write: pmem_write=1, pmem_wmask=d_wmask, pmem_wdata=d_wdata.
  - d_read and d_write both high: treated as a write.
  - Write with d_wmask=00: still issued with mask 00.
- On pmem_resp at edge M:
  - pmem_* drop to 0 at M+1.
  - For reads, pmem_rdata is latched into i_rdata or d_rdata.
  - The granted port's resp is high for exactly cycle M+1 (state RESP). The other port's resp stays 0.
  - RESP returns to IDLE at M+2. The earliest next issue is M+3, so there is at least one idle cycle between memory transactions.
- rdata registers hold their last value after resp falls. The write path does not modify d_rdata.
- Streak counter (4-bit):
  - Incremented on each D grant made while i_read=1; saturates at MAX_D_STREAK.
  - Cleared on any I grant, and on a D grant made with i_read=0.
- Requester drops its request mid-transaction: the memory transaction still completes and the resp pulse is still issued. Latched address/data are used, not live inputs.
- pmem_resp while in IDLE or RESP: ignored.
- Reset mid-transaction: state becomes IDLE and all outputs clear at that edge. No resp pulse is generated for the aborted transaction.

Test Plan:
1. i_read=1, i_address=0x0040; memory asserts pmem_resp 3 cycles after pmem_read with pmem_rdata=0x1234 -> pmem_read high for those 3 cycles with address 0x0040; i_rdata=0x1234 and i_resp=1 for exactly one cycle; d_resp stays 0.
2. Same cycle: i_read=1 (0x0010) and d_read=1 (0x2000), D_PRIORITY=1 -> D served first (pmem_address=0x2000, d_resp), then I (0x0010, i_resp). Two separate transactions with an idle cycle between them.
3. d_read held continuously and i_read held, MAX_D_STREAK=4 -> D granted 4 times, fifth grant goes to I; after the I grant the streak is 0 and D is granted next.
4. d_write=1, d_address=0x3002, d_wdata=0xAB00, d_wmask=10 -> pmem_write=1, pmem_wmask=10, pmem_wdata=0xAB00; then d_resp pulse with d_rdata unchanged.
5. rst asserted while in D_BUSY -> at that edge pmem_* = 0 and state is IDLE; no d_resp pulse even if pmem_resp arrives next cycle.
6. d_read deasserted one cycle after issue -> pmem_address stays at the latched value, d_resp still pulses once on completion, then FSM returns to IDLE and issues nothing further.
